// File: rtl/video_out_h2c_bridge_if.sv
// H2C word stream plus the 24-bit video stream of the playback bridge.
// slave is the bridge's view; master is the host/sink side.
interface video_out_h2c_bridge_if;
  logic [127:0] h2c_tdata;
  logic [15:0]  h2c_tkeep;
  logic         h2c_tlast;
  logic         h2c_tvalid;
  logic         h2c_tready;
  logic [23:0]  axis_vid_tdata;
  logic         axis_vid_tvalid;
  logic         axis_vid_tready;
  logic         axis_vid_tuser;
  logic         axis_vid_tlast;

  modport slave (
    input  h2c_tdata, h2c_tkeep, h2c_tlast, h2c_tvalid,
    output h2c_tready,
    output axis_vid_tdata, axis_vid_tvalid, axis_vid_tuser, axis_vid_tlast,
    input  axis_vid_tready
  );

  modport master (
    output h2c_tdata, h2c_tkeep, h2c_tlast, h2c_tvalid,
    input  h2c_tready,
    input  axis_vid_tdata, axis_vid_tvalid, axis_vid_tuser, axis_vid_tlast,
    output axis_vid_tready
  );
endinterface

// File: rtl/video_out_h2c_bridge.sv
// Playback bridge: unpacks 128-bit H2C words into four 24-bit pixels,
// generates SOF/EOL from x/y counters, checks the host frame boundary,
// counts mid-frame underruns and raises a frame-done IRQ.
module video_out_h2c_bridge #(
  parameter int unsigned FRAME_LINES = 1080,
  parameter int unsigned LINE_PIXELS = 1920
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic                         ctrl_enable,
  input  logic                         ctrl_soft_reset,
  video_out_h2c_bridge_if.slave        bus,
  output logic                         usr_irq_req,
  input  logic                         usr_irq_ack,
  output logic                         sts_frame_err,
  output logic [15:0]                  sts_underrun_cnt
);

  localparam int unsigned XW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int unsigned YW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(LINE_PIXELS - 1);
  localparam logic [XW-1:0] X_LASTW = XW'(LINE_PIXELS - 4);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_LINES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t         state, state_d;
  logic [127:0]   word_q;
  logic           word_valid;
  logic [1:0]     pix_idx;
  logic [XW-1:0]  x, nx;
  logic [YW-1:0]  y, ny;
  logic           miss_pend;
  logic           clr;
  logic           h2c_hs, vid_hs, release_w, is_last_word, early, miss, underrun;
  logic           unused_tkeep;

  assign unused_tkeep = ^bus.h2c_tkeep;
  assign clr          = !ctrl_enable || ctrl_soft_reset;

  assign h2c_hs    = bus.h2c_tvalid && bus.h2c_tready;
  assign vid_hs    = bus.axis_vid_tvalid && bus.axis_vid_tready;
  assign release_w = vid_hs && (pix_idx == 2'd3);

  // Position of the next word's first pixel, i.e. x/y after this cycle's pop.
  always_comb begin
    nx = x;
    ny = y;
    if (vid_hs) begin
      if (x == X_LAST) begin
        nx = '0;
        ny = (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        nx = x + 1'b1;
      end
    end
  end

  assign is_last_word = (nx == X_LASTW) && (ny == Y_LAST);
  assign early        = (state == ACTIVE) && h2c_hs && bus.h2c_tlast && !is_last_word;
  assign miss         = (state == ACTIVE) && h2c_hs && !bus.h2c_tlast && is_last_word;
  assign underrun     = (state == ACTIVE) && !word_valid && bus.axis_vid_tready &&
                        ((x != '0) || (y != '0) || (pix_idx != 2'd0));

  // State register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= IDLE;
    else              state <= state_d;
  end

  // Next-state logic; disable/soft reset override everything.
  always_comb begin
    state_d = state;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    state_d = ACTIVE;
        ACTIVE:  if (release_w && miss_pend) state_d = DRAIN;
        DRAIN:   if (h2c_hs && bus.h2c_tlast) state_d = ACTIVE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs. While the missing-tlast word drains, the refill
  // normally allowed on its last pop is withheld so the next host word is
  // taken by DRAIN and discarded rather than loaded.
  always_comb begin
    bus.h2c_tready      = 1'b0;
    bus.axis_vid_tvalid = 1'b0;
    if (!clr) begin
      case (state)
        ACTIVE: begin
          bus.axis_vid_tvalid = word_valid;
          bus.h2c_tready      = !miss_pend &&
                                (!word_valid || (bus.axis_vid_tready && (pix_idx == 2'd3)));
        end
        DRAIN:   bus.h2c_tready = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.axis_vid_tdata = bus.axis_vid_tvalid ? word_q[{pix_idx, 5'b0} +: 24] : '0;
  assign bus.axis_vid_tuser = bus.axis_vid_tvalid && (x == '0) && (y == '0);
  assign bus.axis_vid_tlast = bus.axis_vid_tvalid && (x == X_LAST);

  // Word register, pixel/line counters, frame check and underrun count.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      word_q           <= '0;
      word_valid       <= 1'b0;
      pix_idx          <= '0;
      x                <= '0;
      y                <= '0;
      miss_pend        <= 1'b0;
      sts_frame_err    <= 1'b0;
      sts_underrun_cnt <= '0;
    end else if (clr) begin
      word_q           <= '0;
      word_valid       <= 1'b0;
      pix_idx          <= '0;
      x                <= '0;
      y                <= '0;
      miss_pend        <= 1'b0;
      sts_frame_err    <= 1'b0;
      sts_underrun_cnt <= '0;
    end else begin
      case (state)
        ACTIVE: begin
          x <= nx;
          y <= ny;
          if (vid_hs) pix_idx <= pix_idx + 2'd1;
          if (release_w) begin
            word_valid <= 1'b0;
            miss_pend  <= 1'b0;
            if (miss_pend) sts_frame_err <= 1'b1;
          end
          if (h2c_hs) begin
            if (early) begin
              x             <= '0;
              y             <= '0;
              pix_idx       <= '0;
              sts_frame_err <= 1'b1;
            end else begin
              word_q     <= bus.h2c_tdata;
              word_valid <= 1'b1;
              if (miss) miss_pend <= 1'b1;
            end
          end
          if (underrun && (sts_underrun_cnt != '1))
            sts_underrun_cnt <= sts_underrun_cnt + 16'd1;
        end
        DRAIN: begin
          if (h2c_hs && bus.h2c_tlast) begin
            x          <= '0;
            y          <= '0;
            pix_idx    <= '0;
            word_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame-done IRQ: set wins over ack; survives disable/soft reset.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)                                          usr_irq_req <= 1'b0;
    else if (vid_hs && bus.axis_vid_tlast && (y == Y_LAST))    usr_irq_req <= 1'b1;
    else if (usr_irq_ack)                                      usr_irq_req <= 1'b0;
  end

endmodule

// File: tb/tb_video_out_h2c_bridge.sv
// Scoreboard bench for video_out_h2c_bridge with an 8x2 frame (4 words).
module tb_video_out_h2c_bridge;
  localparam int unsigned LP = 8;
  localparam int unsigned FL = 2;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        ctrl_enable = 1'b0;
  logic        ctrl_soft_reset = 1'b0;
  logic        usr_irq_ack = 1'b0;
  logic        usr_irq_req;
  logic        sts_frame_err;
  logic [15:0] sts_underrun_cnt;

  video_out_h2c_bridge_if vif();

  video_out_h2c_bridge #(.FRAME_LINES(FL), .LINE_PIXELS(LP)) dut (
    .axi_aclk         (axi_aclk),
    .axi_aresetn      (axi_aresetn),
    .ctrl_enable      (ctrl_enable),
    .ctrl_soft_reset  (ctrl_soft_reset),
    .bus              (vif),
    .usr_irq_req      (usr_irq_req),
    .usr_irq_ack      (usr_irq_ack),
    .sts_frame_err    (sts_frame_err),
    .sts_underrun_cnt (sts_underrun_cnt)
  );

  initial forever #5 axi_aclk = ~axi_aclk;

  typedef struct { logic [23:0] data; logic tuser; logic tlast; } exp_t;
  exp_t expq[$];

  int unsigned n_pass = 0, n_total = 0;
  int unsigned cyc = 0, hs_count = 0;
  int unsigned bp_acc = 0, bp_pix = 0;
  bit          bp_mode = 1'b0, bp_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  function automatic logic [23:0] pix(input int unsigned w, input int unsigned k);
    logic [3:0] wn, kn;
    wn = w[3:0];
    kn = k[3:0];
    return {wn, kn, kn, kn, kn, kn};
  endfunction

  function automatic logic [127:0] mk_word(input int unsigned w);
    logic [127:0] r;
    for (int unsigned k = 0; k < 4; k++) r[32*k +: 32] = {8'hA5, pix(w, k)};
    return r;
  endfunction

  task automatic push_word(input int unsigned w, input int unsigned first_beat);
    exp_t e;
    for (int unsigned k = 0; k < 4; k++) begin
      e.data  = pix(w, k);
      e.tuser = ((first_beat + k) == 0);
      e.tlast = (((first_beat + k) % LP) == LP - 1);
      expq.push_back(e);
    end
  endtask

  task automatic send_word(input int unsigned w, input bit last);
    bit rdy;
    bit done;
    done = 1'b0;
    vif.h2c_tdata  = mk_word(w);
    vif.h2c_tlast  = last;
    vif.h2c_tvalid = 1'b1;
    for (int unsigned t = 0; t < 200 && !done; t++) begin
      @(negedge axi_aclk);
      rdy = vif.h2c_tready;
      @(posedge axi_aclk);
      #1;
      done = rdy;
    end
    if (!done) check("h2c_accept_timeout", 32'd0, 32'd1);
    vif.h2c_tvalid = 1'b0;
    vif.h2c_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int unsigned w0);
    for (int unsigned i = 0; i < 4; i++) push_word(w0 + i, 4 * i);
    for (int unsigned i = 0; i < 4; i++) send_word(w0 + i, i == 3);
  endtask

  task automatic wait_empty(input string name);
    int unsigned t;
    t = 0;
    while (expq.size() != 0 && t < 500) begin
      @(posedge axi_aclk); #1;
      t++;
    end
    if (expq.size() != 0) check(name, expq.size(), 0);
    repeat (2) @(posedge axi_aclk);
    #1;
  endtask

  task automatic ack_irq(input string name);
    check(name, usr_irq_req, 1'b1);
    usr_irq_ack = 1'b1;
    @(posedge axi_aclk); #1;
    usr_irq_ack = 1'b0;
    check({name, "_cleared"}, usr_irq_req, 1'b0);
  endtask

  task automatic soft_pulse();
    ctrl_soft_reset = 1'b1;
    @(posedge axi_aclk); #1;
    ctrl_soft_reset = 1'b0;
    @(posedge axi_aclk); #1;
  endtask

  initial forever begin
    @(posedge axi_aclk);
    cyc++;
  end

  // Sink ready: always 1, or 50% random during the backpressure run.
  initial begin
    vif.axis_vid_tready = 1'b1;
    forever begin
      @(posedge axi_aclk); #1;
      vif.axis_vid_tready = bp_mode ? ($urandom_range(1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every video handshake.
  initial begin
    logic [25:0] held;
    bit          stalled;
    bit          full, pop3, vhs;
    exp_t        e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge axi_aclk);
      vhs = vif.axis_vid_tvalid && vif.axis_vid_tready;
      if (stalled)
        check("stall_hold", {vif.axis_vid_tvalid, vif.axis_vid_tuser, vif.axis_vid_tlast, vif.axis_vid_tdata},
              {1'b1, held});
      stalled = vif.axis_vid_tvalid && !vif.axis_vid_tready;
      held    = {vif.axis_vid_tuser, vif.axis_vid_tlast, vif.axis_vid_tdata};
      if (bp_chk) begin
        full = (bp_acc * 4) > bp_pix;
        pop3 = vhs && ((bp_pix % 4) == 3);
        if (full && !pop3) check("h2c_ready_when_full", vif.h2c_tready, 1'b0);
        if (vif.h2c_tvalid && vif.h2c_tready) bp_acc++;
        if (vhs) bp_pix++;
      end
      if (vhs) begin
        hs_count++;
        if (expq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pixel: got %06h, want no pixel", vif.axis_vid_tdata);
        end else begin
          e = expq.pop_front();
          check("pix_data",  vif.axis_vid_tdata, e.data);
          check("pix_tuser", vif.axis_vid_tuser, e.tuser);
          check("pix_tlast", vif.axis_vid_tlast, e.tlast);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, h0, t;
    vif.h2c_tdata  = '0;
    vif.h2c_tkeep  = '0;
    vif.h2c_tlast  = 1'b0;
    vif.h2c_tvalid = 1'b0;
    repeat (3) @(posedge axi_aclk);
    #1;
    check("rst_h2c_tready", vif.h2c_tready, 1'b0);
    check("rst_vid_tvalid", vif.axis_vid_tvalid, 1'b0);
    check("rst_vid_tuser",  vif.axis_vid_tuser, 1'b0);
    check("rst_vid_tlast",  vif.axis_vid_tlast, 1'b0);
    check("rst_vid_tdata",  vif.axis_vid_tdata, 24'h0);
    check("rst_irq",        usr_irq_req, 1'b0);
    check("rst_frame_err",  sts_frame_err, 1'b0);
    check("rst_underrun",   sts_underrun_cnt, 16'h0);
    axi_aresetn = 1'b1;
    @(posedge axi_aclk); #1;
    ctrl_enable = 1'b1;
    repeat (2) @(posedge axi_aclk);
    #1;

    // Nominal frame, no bubbles.
    for (int unsigned i = 0; i < 4; i++) push_word(i, 4 * i);
    send_word(0, 1'b0);
    c0 = cyc;
    h0 = hs_count;
    for (int unsigned i = 1; i < 4; i++) send_word(i, i == 3);
    while (cyc < c0 + 16) begin
      @(posedge axi_aclk); #1;
    end
    check("nominal_16_pixels_no_bubble", hs_count - h0, 16);
    check("nominal_irq_set", usr_irq_req, 1'b1);
    repeat (3) @(posedge axi_aclk);
    #1;
    ack_irq("nominal_irq_held");

    // Random sink backpressure.
    bp_acc  = 0;
    bp_pix  = 0;
    bp_chk  = 1'b1;
    bp_mode = 1'b1;
    send_frame(0);
    wait_empty("bp_drain_timeout");
    bp_chk  = 1'b0;
    bp_mode = 1'b0;
    ack_irq("bp_irq");

    // Underrun: 3-cycle host gap mid-frame, then a gap between frames.
    soft_pulse();
    check("ur_cleared", sts_underrun_cnt, 16'd0);
    for (int unsigned i = 0; i < 4; i++) push_word(i, 4 * i);
    send_word(0, 1'b0);
    send_word(1, 1'b0);
    t = 0;
    do begin
      @(negedge axi_aclk);
      t++;
    end while (!vif.h2c_tready && t < 100);
    repeat (3) @(posedge axi_aclk);
    #1;
    send_word(2, 1'b0);
    send_word(3, 1'b1);
    repeat (6) @(posedge axi_aclk);
    #1;
    send_frame(4);
    wait_empty("ur_drain_timeout");
    check("underrun_cnt", sts_underrun_cnt, 16'd3);
    ack_irq("ur_irq");

    // Early tlast on word 1.
    check("early_err_before", sts_frame_err, 1'b0);
    push_word(0, 0);
    send_word(0, 1'b0);
    send_word(1, 1'b1);
    check("early_frame_err", sts_frame_err, 1'b1);
    push_word(2, 0);
    push_word(3, 4);
    push_word(4, 8);
    push_word(5, 12);
    for (int unsigned i = 2; i < 6; i++) send_word(i, i == 5);
    wait_empty("early_drain_timeout");
    ack_irq("early_irq");

    // Soft reset pulse at pixel 5.
    push_word(0, 0);
    push_word(1, 4);
    h0 = hs_count;
    send_word(0, 1'b0);
    send_word(1, 1'b0);
    t = 0;
    while (hs_count < h0 + 5 && t < 100) begin
      @(posedge axi_aclk); #1;
      t++;
    end
    check("sr_reached_pixel5", hs_count - h0, 5);
    ctrl_soft_reset = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge axi_aclk);
      check("sr_h2c_tready", vif.h2c_tready, 1'b0);
      check("sr_vid_tvalid", vif.axis_vid_tvalid, 1'b0);
      @(posedge axi_aclk); #1;
    end
    ctrl_soft_reset = 1'b0;
    expq.delete();
    check("sr_frame_err_clr", sts_frame_err, 1'b0);
    check("sr_underrun_clr", sts_underrun_cnt, 16'd0);
    send_frame(8);
    wait_empty("sr_drain_timeout");
    ack_irq("sr_irq");

    // Missing tlast on word 3; words 4, 5 discarded.
    soft_pulse();
    for (int unsigned i = 0; i < 4; i++) push_word(i, 4 * i);
    for (int unsigned i = 0; i < 4; i++) send_word(i, 1'b0);
    send_word(4, 1'b0);
    send_word(5, 1'b1);
    for (int unsigned i = 6; i < 10; i++) push_word(i, 4 * (i - 6));
    for (int unsigned i = 6; i < 10; i++) send_word(i, i == 9);
    wait_empty("miss_drain_timeout");
    check("miss_frame_err", sts_frame_err, 1'b1);
    ack_irq("miss_irq");

    check("scoreboard_empty_end", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
